// File: rtl/neuraedge_pkg.sv
// -----------------------------------------------------------------------------
// neuraedge_pkg
// Shared constants and stage types for the NeuraEdge requantization path.
//
// Contents:
//   ACCUM_WIDTH / OUT_WIDTH / SCALE_WIDTH / SHIFT_WIDTH : datapath widths
//   PROD_WIDTH   : width of bias-added sum times scale
//   QMIN / QMAX  : output clamp range
//   s2_stage_t   : S2->S3 pipeline register (prod, shift, valid)
//
// Build option: NEURAEDGE_REQUANT_RELU_EN narrows the clamp range to [0, QMAX].
// -----------------------------------------------------------------------------
package neuraedge_pkg;

   localparam int unsigned ACCUM_WIDTH = 32;
   localparam int unsigned OUT_WIDTH   = 8;
   localparam int unsigned SCALE_WIDTH = 16;
   localparam int unsigned SHIFT_WIDTH = 6;
   localparam int unsigned PROD_WIDTH  = ACCUM_WIDTH + 1 + SCALE_WIDTH;

   localparam int QMAX = 127;
`ifdef NEURAEDGE_REQUANT_RELU_EN
   localparam int QMIN = 0;
`else
   localparam int QMIN = -128;
`endif

   typedef struct packed {
      logic signed [PROD_WIDTH-1:0] prod;
      logic        [SHIFT_WIDTH-1:0] shift;
      logic                          valid;
   } s2_stage_t;

endpackage

// File: rtl/neuraedge_round_clamp.sv
// -----------------------------------------------------------------------------
// neuraedge_round_clamp
// Combinational rounding right shift followed by a clamp to [QMIN, QMAX].
// Rounding is round-half-up (toward +inf): add 1<<(shift-1), then shift
// arithmetically. The addend path is one bit wider than the product.
//
// Ports:
//   i_prod  : signed scaled product
//   i_shift : right-shift amount (0..63)
//   o_data  : clamped signed activation
//   o_sat   : clamped value differs from the rounded value
//
// Build option: NEURAEDGE_REQUANT_RELU_EN -- negative results clamp to 0 and
// are not reported as saturation.
// -----------------------------------------------------------------------------
module neuraedge_round_clamp
   import neuraedge_pkg::*;
(
   input  logic signed [PROD_WIDTH-1:0]  i_prod,
   input  logic        [SHIFT_WIDTH-1:0] i_shift,
   output logic signed [OUT_WIDTH-1:0]   o_data,
   output logic                          o_sat
);

   localparam int unsigned RW = PROD_WIDTH + 1;

   localparam logic signed [RW-1:0] W_QMAX = RW'(QMAX);
   localparam logic signed [RW-1:0] W_QMIN = RW'(QMIN);

   logic signed [RW-1:0] w_addend;
   logic signed [RW-1:0] w_sum;
   logic signed [RW-1:0] w_shifted;

   always_comb begin
      w_addend = '0;
      if (i_shift != '0) begin
         w_addend = {{(RW-1){1'b0}}, 1'b1} << (i_shift - 1'b1);
      end
      w_sum     = {i_prod[PROD_WIDTH-1], i_prod} + w_addend;
      w_shifted = w_sum >>> i_shift;
   end

   always_comb begin
      o_data = w_shifted[OUT_WIDTH-1:0];
      o_sat  = 1'b0;
      if (w_shifted > W_QMAX) begin
         o_data = OUT_WIDTH'(QMAX);
         o_sat  = 1'b1;
      end else if (w_shifted < W_QMIN) begin
         o_data = OUT_WIDTH'(QMIN);
`ifdef NEURAEDGE_REQUANT_RELU_EN
         o_sat  = 1'b0;
`else
         o_sat  = 1'b1;
`endif
      end
   end

endmodule

// File: rtl/neuraedge_requant.sv
// -----------------------------------------------------------------------------
// neuraedge_requant
// Three-stage valid/ready requantization pipeline downstream of the PE:
//   S1: sum  = accum + bias           (ACCUM_WIDTH+1 bits)
//   S2: prod = sum * scale            (ACCUM_WIDTH+1+SCALE_WIDTH bits)
//   S3: rounding shift + clamp to an OUT_WIDTH activation, tile-last marking
// Configuration (bias/scale/shift) is captured with each element on accept.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready = !(out_valid && !out_ready)
//   in_accum            : signed accumulator
//   cfg_bias/scale/shift: per-element configuration, sampled on accept
//   cfg_tile_len        : outputs per tile (0 = never assert out_last)
//   out_valid/out_ready : output handshake
//   out_data, out_last  : activation and end-of-tile marker
//   stat_clear          : synchronous clear of sat_count (wins over increment)
//   sat_count           : saturating count of clamped output transfers
//
// Build option: NEURAEDGE_REQUANT_RELU_EN (see neuraedge_round_clamp).
// -----------------------------------------------------------------------------
module neuraedge_requant #(
   parameter int unsigned ACCUM_WIDTH = neuraedge_pkg::ACCUM_WIDTH,
   parameter int unsigned OUT_WIDTH   = neuraedge_pkg::OUT_WIDTH,
   parameter int unsigned SCALE_WIDTH = neuraedge_pkg::SCALE_WIDTH,
   parameter int unsigned SHIFT_WIDTH = neuraedge_pkg::SHIFT_WIDTH,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [ACCUM_WIDTH-1:0] in_accum,
   input  logic signed [ACCUM_WIDTH-1:0] cfg_bias,
   input  logic signed [SCALE_WIDTH-1:0] cfg_scale,
   input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic        [LEN_WIDTH-1:0]   cfg_tile_len,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_last,
   input  logic                          stat_clear,
   output logic        [15:0]            sat_count
);

   import neuraedge_pkg::*;

   localparam int unsigned SUM_W  = ACCUM_WIDTH + 1;
   localparam int unsigned PROD_W = ACCUM_WIDTH + 1 + SCALE_WIDTH;

   logic w_stall;
   logic w_out_fire;

   // S1 registers
   logic                     r_s1_valid;
   logic signed [SUM_W-1:0]  r_s1_sum;
   logic signed [SCALE_WIDTH-1:0] r_s1_scale;
   logic [SHIFT_WIDTH-1:0]   r_s1_shift;

   // S2 register
   s2_stage_t                r_s2;
   logic signed [PROD_W-1:0] w_prod;

   // S3 / output registers
   logic                     r_out_valid;
   logic signed [OUT_WIDTH-1:0] r_out_data;
   logic                     r_out_last;
   logic                     r_out_sat;
   logic [LEN_WIDTH-1:0]     r_cnt;
   logic [LEN_WIDTH-1:0]     w_cnt_next;
   logic [15:0]              r_sat_count;

   logic signed [OUT_WIDTH-1:0] w_rc_data;
   logic                     w_rc_sat;
   logic                     w_next_last;

   assign w_stall    = r_out_valid & ~out_ready;
   assign w_out_fire = r_out_valid & out_ready;
   assign in_ready   = ~w_stall;

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;
   assign sat_count  = r_sat_count;

   // ---------------- S1: bias add ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_scale <= '0;
         r_s1_shift <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sum   <= SUM_W'(in_accum) + SUM_W'(cfg_bias);
            r_s1_scale <= cfg_scale;
            r_s1_shift <= cfg_shift;
         end
      end
   end

   // ---------------- S2: scale multiply ----------------
   assign w_prod = PROD_W'(r_s1_sum) * PROD_W'(r_s1_scale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2 <= '0;
      end else if (!w_stall) begin
         r_s2.valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2.prod  <= w_prod;
            r_s2.shift <= r_s1_shift;
         end
      end
   end

   // ---------------- S3: round, clamp, tile marking ----------------
   neuraedge_round_clamp u_round_clamp (
      .i_prod  (r_s2.prod),
      .i_shift (r_s2.shift),
      .o_data  (w_rc_data),
      .o_sat   (w_rc_sat)
   );

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_out_fire) begin
         w_cnt_next = r_out_last ? '0 : r_cnt + LEN_WIDTH'(1);
      end
   end

   // out_last is precomputed against the count the element will see once it
   // becomes the head, so it is a register rather than a path from cfg_tile_len.
   assign w_next_last = r_s2.valid && (cfg_tile_len != '0) &&
                        (w_cnt_next == cfg_tile_len - LEN_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_sat   <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= r_s2.valid;
         r_out_last  <= w_next_last;
         r_out_sat   <= r_s2.valid & w_rc_sat;
         if (r_s2.valid) begin
            r_out_data <= w_rc_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_count <= '0;
      end else if (stat_clear) begin
         r_sat_count <= '0;
      end else if (w_out_fire && r_out_sat && (r_sat_count != '1)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_neuraedge_requant.sv
// -----------------------------------------------------------------------------
// tb_neuraedge_requant
// Directed self-checking bench for neuraedge_requant. Expected values are
// hand-computed; the ReLU build (NEURAEDGE_REQUANT_RELU_EN) selects the
// alternative expectations.
// -----------------------------------------------------------------------------
module tb_neuraedge_requant;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_accum;
   logic signed [31:0] cfg_bias;
   logic signed [15:0] cfg_scale;
   logic        [5:0]  cfg_shift;
   logic        [15:0] cfg_tile_len;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic               out_last;
   logic               stat_clear;
   logic        [15:0] sat_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuraedge_requant #(
      .ACCUM_WIDTH (32),
      .OUT_WIDTH   (8),
      .SCALE_WIDTH (16),
      .SHIFT_WIDTH (6),
      .LEN_WIDTH   (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_accum     (in_accum),
      .cfg_bias     (cfg_bias),
      .cfg_scale    (cfg_scale),
      .cfg_shift    (cfg_shift),
      .cfg_tile_len (cfg_tile_len),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .stat_clear   (stat_clear),
      .sat_count    (sat_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int acc, input int bias, input int scale, input int shift);
      in_accum  = acc;
      cfg_bias  = bias;
      cfg_scale = 16'(scale);
      cfg_shift = 6'(shift);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
      cfg_tile_len = '0;
      set_in(0, 0, 1, 0);
      tick(); tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
      rst_n = 1'b1;
      tick();
   endtask

   // Single element, checks 3-cycle latency, value and sat count after transfer.
   task automatic single(input string name, input int acc, input int bias, input int scale,
                         input int shift, input int exp_data, input int exp_sat_cnt);
      logic [7:0] e;
      e = 8'(exp_data);
      set_in(acc, bias, scale, shift);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid_cycle3: got %b want 1", name, out_valid); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL %s_data: got %0d want %0d", name, out_data, exp_data); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b want 0", name, out_valid); end
      checks++; if (sat_count !== 16'(exp_sat_cnt)) begin errors++; $display("FAIL %s_sat_count: got %0d want %0d", name, sat_count, exp_sat_cnt); end
   endtask

   task automatic test_saturate;
      single("sat_1000", 1000, 24, 1, 3, 127, 1);
   endtask

   task automatic test_negative;
`ifdef NEURAEDGE_REQUANT_RELU_EN
      single("neg_37", -37, 0, 3, 2, 0, 1);
`else
      single("neg_37", -37, 0, 3, 2, -28, 1);
`endif
   endtask

   task automatic test_rounding;
      int acc [12];
      int bias[12];
      int scl [12];
      int shf [12];
      int exp_d[12];
      int exp_sats;
      int nout;
      acc  = '{-5, 5, -300, 100, 100, -100, 10, 1000, -129, 1572864, 32'h7FFFFFFF, 1000000};
      bias = '{ 0, 0,    0,  27,  28,  -28,  0,    0,    0,       0,           1,       0};
      scl  = '{ 1, 1,    1,   1,   1,    1, -3,    1,    1,       1,           1,   30000};
      shf  = '{ 1, 1,    0,   0,   0,    0,  0,    4,    0,      20,          24,      28};
`ifdef NEURAEDGE_REQUANT_RELU_EN
      exp_d = '{0, 3, 0, 127, 127, 0, 0, 63, 0, 2, 127, 112};
      exp_sats = 2;
`else
      exp_d = '{-2, 3, -128, 127, 127, -128, -30, 63, -128, 2, 127, 112};
      exp_sats = 4;
`endif
      nout = 0;
      for (int c = 0; c < 18; c++) begin
         if (c < 12) begin
            set_in(acc[c], bias[c], scl[c], shf[c]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid === 1'b1) begin
            checks++;
            if (nout >= 12) begin
               errors++; $display("FAIL round_extra_output: got %0d outputs want 12", nout + 1);
            end else if (out_data !== 8'(exp_d[nout])) begin
               errors++; $display("FAIL round_vec%0d: got %0d want %0d", nout, out_data, exp_d[nout]);
            end
            nout++;
         end
      end
      checks++; if (nout != 12) begin errors++; $display("FAIL round_count: got %0d want 12", nout); end
      checks++; if (sat_count !== 16'(1 + exp_sats)) begin errors++; $display("FAIL round_sat_count: got %0d want %0d", sat_count, 1 + exp_sats); end
   endtask

   task automatic test_tile;
      int nout;
      logic exp_last;
      do_reset();
      cfg_tile_len = 16'd4;
      nout = 0;
      for (int c = 0; c < 18; c++) begin
         if (c < 12) begin
            set_in(c + 1, 0, 1, 0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid === 1'b1) begin
            exp_last = (nout == 3) || (nout == 7) || (nout == 11);
            checks++;
            if (out_data !== 8'(nout + 1)) begin errors++; $display("FAIL tile_data%0d: got %0d want %0d", nout, out_data, nout + 1); end
            checks++;
            if (out_last !== exp_last) begin errors++; $display("FAIL tile_last%0d: got %b want %b", nout, out_last, exp_last); end
            nout++;
         end
      end
      checks++; if (nout != 12) begin errors++; $display("FAIL tile_count: got %0d want 12", nout); end
      cfg_tile_len = '0;
   endtask

   task automatic test_back_to_back_stall;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(10 * (i + 1), 0, 1, 0);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b want 0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_data !== 8'sd10) begin errors++; $display("FAIL stall_hold%0d: got v=%b d=%0d want v=1 d=10", k, out_valid, out_data); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(10 * (i + 1))) begin
            errors++; $display("FAIL stall_drain%0d: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, 10 * (i + 1));
         end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_stat_clear;
      do_reset();
      set_in(1000, 24, 1, 3);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (sat_count !== 16'd5) begin errors++; $display("FAIL clr_pre_count: got %0d want 5", sat_count); end
      out_ready = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_head_valid: got %b want 1", out_valid); end
      out_ready = 1'b1;
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_same_cycle: got %0d want 0", sat_count); end
      tick();
      checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_stays_zero: got %0d want 0", sat_count); end
   endtask

   task automatic test_reset_midflight;
      int nout;
      int first_c;
      do_reset();
      cfg_tile_len = 16'd2;
      // one element through, leaving the tile counter at 1
      set_in(1, 0, 1, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      // two elements in flight, then reset
      set_in(50, 0, 1, 0); in_valid = 1'b1; tick();
      set_in(60, 0, 1, 0); tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_last !== 1'b0 || sat_count !== 16'd0) begin
         errors++; $display("FAIL midrst_outputs: got v=%b d=%0d l=%b s=%0d want all 0", out_valid, out_data, out_last, sat_count);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output%0d: got %b want 0", k, out_valid); end
      end
      nout = 0;
      first_c = -1;
      for (int c = 0; c < 8; c++) begin
         if (c < 2) begin
            set_in(5 + c, 0, 1, 0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid === 1'b1) begin
            if (first_c < 0) first_c = c;
            checks++;
            if (nout > 1 || out_data !== 8'(5 + nout) || out_last !== (nout == 1)) begin
               errors++; $display("FAIL midrst_post%0d: got d=%0d l=%b want d=%0d l=%b", nout, out_data, out_last, 5 + nout, (nout == 1));
            end
            nout++;
         end
      end
      checks++; if (first_c != 2) begin errors++; $display("FAIL midrst_latency: got tick %0d want 2", first_c); end
      checks++; if (nout != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", nout); end
   endtask

   initial begin
      test_reset();
      test_saturate();
      test_negative();
      test_rounding();
      test_tile();
      test_back_to_back_stall();
      test_stat_clear();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/neuraedge_requant.md
# neuraedge_requant

Requantization output stage, directly downstream of the processing element: it consumes the PE's 32-bit signed `accum_out` values and converts each to an 8-bit signed activation. The datapath adds bias, multiplies by a fixed-point scale, applies a rounding right shift, then clamps. It is a 3-stage valid/ready pipeline and marks the last element of each output tile for the writeback path. Saturation events are counted for debug.

## Interface
- `ACCUM_WIDTH`, 32: input accumulator width (signed).
- `OUT_WIDTH`, 8: output activation width (signed).
- `SCALE_WIDTH`, 16: multiplier width (signed).
- `SHIFT_WIDTH`, 6: right-shift amount width (unsigned, 0..63).
- `LEN_WIDTH`, 16: tile-length counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: accumulator word valid.
- `in_ready` out 1: stage can accept.
- `in_accum` in ACCUM_WIDTH: signed accumulator.
- `cfg_bias` in ACCUM_WIDTH: signed bias; sampled on accept.
- `cfg_scale` in SCALE_WIDTH: signed scale; sampled on accept.
- `cfg_shift` in SHIFT_WIDTH: rounding shift; sampled on accept.
- `cfg_tile_len` in LEN_WIDTH: outputs per tile; 0 means `out_last` is never asserted.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out OUT_WIDTH: signed activation.
- `out_last` out 1: final element of the tile.
- `stat_clear` in 1: synchronous clear of `sat_count`.
- `sat_count` out 16: saturating count of clamped outputs.

## Operation
- Transfer: input occurs when `in_valid && in_ready`; output occurs when `out_valid && out_ready`.
- `stall = out_valid && !out_ready`.
  - All stage registers hold when stalled.
  - `in_ready = !stall`, so bubbles collapse.
- Cfg values are captured with the data on accept and travel down the pipe. Changing cfg mid-stream affects only later elements.
- S1: `sum = sext(in_accum) + sext(cfg_bias)`, ACCUM_WIDTH+1 bits. No overflow is possible.
- S2: `prod = sum * cfg_scale`, signed, ACCUM_WIDTH+1+SCALE_WIDTH bits (49).
- S3 rounding: `r = (prod + (shift ? 1<<(shift-1) : 0)) >>> shift`.
  - Arithmetic shift; round-half-up toward +inf.
  - Rounding addend uses a width one bit wider than `prod`.
- S3 clamp: clamp `r` to [-128, 127].
  - A saturation event occurs when the clamped value differs from `r`.
- Tile counter `cnt` (LEN_WIDTH bits):
  - Increments on each output transfer.
  - `out_last = out_valid && tile_len!=0 && cnt==tile_len-1`.
  - When an output transfer has `out_last` set, `cnt` returns to 0.
  - If `cnt` passes `tile_len` (length lowered mid-tile), it keeps incrementing and wraps at 2^LEN_WIDTH.
- `sat_count`:
  - Increments once per output transfer that carries a saturation event.
  - Sticks at 0xFFFF.
  - `stat_clear` wins over a same-cycle increment, leaving the value 0.

## Timing
- Latency: 3 cycles from input transfer to `out_valid`, with no stall.
- Throughput: 1 element per cycle.
- Reset values: all stage valids 0; `out_valid` 0; `out_data` 0; `out_last` 0; `sat_count` 0; `cnt` 0.
- `in_ready` is 1 during reset, because no stall is possible.
- Reset mid-operation discards in-flight elements without emitting them.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- Simultaneous input transfer and output transfer in the same cycle is legal; occupancy is unchanged.
- `in_ready` is combinational from `out_ready` and `out_valid`. No other combinational input-to-output paths exist.

## Configuration
- `NEURAEDGE_REQUANT_RELU_EN`:
  - Defined: the clamp range becomes [0, 127]. Negative `r` yields 0 and is NOT counted as saturation.
  - Undefined: signed clamp [-128, 127] as above.
  - The pipeline depth is identical in both builds.

## Structure
- Shared package `neuraedge_pkg` holds:
  - `ACCUM_WIDTH`, `OUT_WIDTH`, `SCALE_WIDTH` constants.
  - `QMIN`/`QMAX` constants.
  - An S2→S3 stage struct typedef (`prod`, `shift`, `valid`).
- Sub-module `neuraedge_round_clamp`: the combinational S3 shift/round/clamp plus sat flag. It is reused by the future vector-unit writeback.

## Test plan
- `accum=1000`, `bias=24`, `scale=1`, `shift=3`: `(1024+4)>>>3 = 128` → `out_data=127`, saturated; `sat_count=1`, valid at cycle 3.
- `accum=-37`, `bias=0`, `scale=3`, `shift=2`: `(-111+2)>>>2 = -28` → `out_data=-28` (ReLU build: 0, `sat_count` unchanged).
- `tile_len=4`, 10 back-to-back inputs with `out_ready=1` → `out_last` on outputs 4 and 8 only; `cnt=2` at end.
- Hold `out_ready=0` for 5 cycles after 3 inputs → `in_ready=0`; `out_data` stable. On release, 3 outputs on consecutive cycles with order preserved.
- `stat_clear` in the same cycle as a saturating output transfer, with `sat_count=5` → `sat_count=0`.
- Assert `rst_n` low with 2 elements in flight → no output appears; all outputs 0. The first element after reset emerges 3 cycles after acceptance with `cnt` restarted.
